// File: rtl/fp_ci_master.sv
// Custom-instruction master: issues one operand pair to a multi-cycle FP unit and returns its result.
// Define FP_CI_MASTER_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles with a timeout response.
module fp_ci_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_dataa,
    input  logic [31:0] cmd_datab,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_timeout,
    output logic        ci_clk_en,
    output logic [31:0] ci_dataa,
    output logic [31:0] ci_datab,
    input  logic [31:0] ci_result,
    input  logic        ci_done,
    output logic [15:0] op_count
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("fp_ci_master: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q;
    logic        ci_clk_en_q;
    logic        rsp_valid_q;
    logic [31:0] ci_dataa_q;
    logic [31:0] ci_datab_q;
    logic [31:0] rsp_result_q;
    logic [15:0] op_count_q;

`ifdef FP_CI_MASTER_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt_q;
    logic       rsp_timeout_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            ci_clk_en_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            ci_dataa_q    <= '0;
            ci_datab_q    <= '0;
            rsp_result_q  <= '0;
            op_count_q    <= '0;
`ifdef FP_CI_MASTER_TIMEOUT_EN
            wait_cnt_q    <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            ci_clk_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        ci_dataa_q  <= cmd_dataa;
                        ci_datab_q  <= cmd_datab;
                        ci_clk_en_q <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
`ifdef FP_CI_MASTER_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    state_q <= StWait;
                end
                StWait: begin
                    // Done is checked first so it wins over a simultaneous timeout.
                    if (ci_done) begin
                        rsp_result_q  <= ci_result;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= StResp;
`ifdef FP_CI_MASTER_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
                    end else if (wait_cnt_q == TimeoutLast) begin
                        rsp_result_q  <= '0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= StResp;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
`endif
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                        if (op_count_q != 16'hFFFF) begin
                            op_count_q <= op_count_q + 16'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign ci_clk_en  = ci_clk_en_q;
    assign rsp_valid  = rsp_valid_q;
    assign ci_dataa   = ci_dataa_q;
    assign ci_datab   = ci_datab_q;
    assign rsp_result = rsp_result_q;
    assign op_count   = op_count_q;
`ifdef FP_CI_MASTER_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fp_ci_master.sv
// Self-checking bench for fp_ci_master: vector table, corner sequences and randomized operations.
module tb_fp_ci_master;

`ifdef FP_CI_MASTER_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 16;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_dataa = '0;
    logic [31:0] cmd_datab = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_timeout;
    logic        ci_clk_en;
    logic [31:0] ci_dataa;
    logic [31:0] ci_datab;
    logic [31:0] ci_result;
    logic        ci_done;
    logic [15:0] op_count;

    fp_ci_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dataa  (cmd_dataa),
        .cmd_datab  (cmd_datab),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_timeout(rsp_timeout),
        .ci_clk_en  (ci_clk_en),
        .ci_dataa   (ci_dataa),
        .ci_datab   (ci_datab),
        .ci_result  (ci_result),
        .ci_done    (ci_done),
        .op_count   (op_count)
    );

    always #5 clock = ~clock;

    // Unit model: done is sampled d+1 rising edges after the edge that sampled clk_en; d=0 never.
    int          unit_delay = 0;
    logic [31:0] unit_res = '0;
    int          unit_cnt = 0;
    logic        unit_done = 1'b0;
    logic        spur_done = 1'b0;

    always @(negedge clock) begin
        unit_done <= 1'b0;
        if (ci_clk_en) begin
            unit_cnt <= (unit_delay > 0) ? unit_delay + 1 : 0;
        end else if (unit_cnt > 0) begin
            unit_cnt <= unit_cnt - 1;
            if (unit_cnt == 1) unit_done <= 1'b1;
        end
    end

    assign ci_done   = unit_done | spur_done;
    assign ci_result = unit_done ? unit_res : 32'hDEADBEEF;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] cnt_model = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_unit(input logic [31:0] a, input logic [31:0] b);
        return a ^ {b[15:0], b[31:16]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] unit_res;
        int          delay;
        int          hold;
        logic [31:0] exp_res;
        logic        exp_to;
        int          exp_lat;
    } vec_t;

    // One complete operation; latency t counts rising edges after the accepting edge.
    task automatic do_vec(input vec_t v);
        int t;
        int pulses;
        @(negedge clock);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid  = 1'b1;
        cmd_dataa  = v.a;
        cmd_datab  = v.b;
        unit_delay = v.delay;
        unit_res   = v.unit_res;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_dataa = $urandom;
        cmd_datab = $urandom;
        t = 0;
        pulses = 0;
        while (!rsp_valid && t < 64) begin
            if (ci_clk_en) pulses++;
            if (ci_dataa !== v.a || ci_datab !== v.b || cmd_ready !== 1'b0) begin
                chk("operands_busy", {ci_dataa ^ v.a} | {31'd0, cmd_ready}, 32'd0);
            end
            @(negedge clock);
            t++;
        end
        chk("latency", t, v.exp_lat);
        chk("clk_en_pulses", pulses, 1);
        chk("rsp_result", rsp_result, v.exp_res);
        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, v.exp_to});
        for (int i = 0; i < v.hold; i++) begin
            spur_done = (i == 0);
            @(negedge clock);
            spur_done = 1'b0;
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_result", rsp_result, v.exp_res);
            chk("hold_ready", {30'd0, cmd_ready, ci_clk_en}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        cnt_model = sat_inc(cnt_model);
        chk("post_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("op_count", {16'd0, op_count}, {16'd0, cnt_model});
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("rst_outputs", {28'd0, ci_clk_en, rsp_valid, rsp_timeout, cmd_ready}, 32'd1);
        chk("rst_dataa", ci_dataa, 32'd0);
        chk("rst_datab", ci_datab, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        cnt_model = '0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    vec_t vecs[4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        int   hs;
        int   pulses;
        int   last_pulse;

        vecs[0] = '{32'h3F800000, 32'h40000000, 32'h00000004, 3, 0, 32'h00000004, 1'b0, 5};
        vecs[1] = '{32'h11112222, 32'h33334444, 32'hCAFEF00D, 2, 10, 32'hCAFEF00D, 1'b0, 4};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 32'h80000001, 1, 1, 32'h80000001, 1'b0, 3};
        vecs[3] = '{32'h7F7FFFFF, 32'hFF800000, 32'h0BADC0DE, 7, 2, 32'h0BADC0DE, 1'b0, 9};

        #2;
        reset_n = 1'b0;
        #1;
        chk("init_outputs", {28'd0, ci_clk_en, rsp_valid, rsp_timeout, cmd_ready}, 32'd1);
        chk("init_data", ci_dataa | ci_datab | rsp_result, 32'd0);
        chk("init_op_count", {16'd0, op_count}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) do_vec(vecs[i]);

        // Back-to-back commands with cmd_valid held high.
        @(negedge clock);
        rsp_ready  = 1'b1;
        cmd_valid  = 1'b1;
        cmd_dataa  = 32'h01020304;
        cmd_datab  = 32'h05060708;
        unit_delay = 1;
        unit_res   = 32'h0000BEEF;
        hs = 0;
        pulses = 0;
        last_pulse = -100;
        for (int c = 0; c < 60 && hs < 3; c++) begin
            @(negedge clock);
            if (ci_clk_en) begin
                if (pulses > 0) chk("b2b_gap_ge4", {31'd0, (c - last_pulse) >= 4}, 32'd1);
                pulses++;
                last_pulse = c;
            end
            if ((ci_clk_en || rsp_valid) && cmd_ready) chk("b2b_cmd_ready", 32'd1, 32'd0);
            if (rsp_valid) begin
                hs++;
                cnt_model = sat_inc(cnt_model);
                if (hs == 3) cmd_valid = 1'b0;
            end
        end
        @(negedge clock);
        rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (ci_clk_en) pulses++;
        end
        chk("b2b_handshakes", hs, 3);
        chk("b2b_pulses", pulses, 3);
        chk("b2b_op_count", {16'd0, op_count}, {16'd0, cnt_model});

        // Randomized operations against the reference unit function.
        for (int i = 0; i < 20; i++) begin
            v.a        = $urandom;
            v.b        = $urandom;
            v.unit_res = ref_unit(v.a, v.b);
            v.delay    = $urandom_range(1, 6);
            v.hold     = $urandom_range(0, 3);
            v.exp_res  = ref_unit(v.a, v.b);
            v.exp_to   = 1'b0;
            v.exp_lat  = v.delay + 2;
            do_vec(v);
        end

`ifdef FP_CI_MASTER_TIMEOUT_EN
        v = '{32'hAAAA5555, 32'h5555AAAA, 32'h12345678, 0, 2, 32'h0, 1'b1, TO + 1};
        do_vec(v);
        v = '{32'h0F0F0F0F, 32'hF0F0F0F0, 32'h87654321, TO - 1, 1, 32'h87654321, 1'b0, TO + 1};
        do_vec(v);
`else
        // Unit never completes: no response may ever appear.
        @(negedge clock);
        cmd_valid  = 1'b1;
        cmd_dataa  = 32'hAAAA5555;
        cmd_datab  = 32'h5555AAAA;
        unit_delay = 0;
        @(negedge clock);
        cmd_valid = 1'b0;
        hs = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (rsp_valid || rsp_timeout) hs++;
        end
        chk("no_timeout_resp", hs, 0);
        do_reset();
`endif

        // Reset two cycles into WAIT; the later done must be ignored.
        @(negedge clock);
        cmd_valid  = 1'b1;
        cmd_dataa  = 32'h3F800000;
        cmd_datab  = 32'h40000000;
        unit_delay = 5;
        unit_res   = 32'h00000004;
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        do_reset();
        hs = 0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (rsp_valid) hs++;
            if (ci_clk_en) pulses++;
        end
        chk("rst_no_resp", hs, 0);
        chk("rst_no_clk_en", pulses, 0);
        chk("rst_op_count_after", {16'd0, op_count}, 32'd0);
        chk("rst_idle", {31'd0, cmd_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_ci_master.md
FP_CI_MASTER -- requirements
Module: fp_ci_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum WAIT cycles before abort, valid range 1..255.
REQ-002 clock  in  1  single clock; all logic is on the rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  upstream operand pair is valid.
REQ-005 cmd_ready  out  1  block accepts a command; high only in IDLE.
REQ-006 cmd_dataa  in  32  operand A (IEEE-754 single).
REQ-007 cmd_datab  in  32  operand B (IEEE-754 single).
REQ-008 rsp_valid  out  1  response is valid.
REQ-009 rsp_ready  in  1  downstream accepts the response.
REQ-010 rsp_result  out  32  captured unit result.
REQ-011 rsp_timeout  out  1  response was produced by timeout, not by done.
REQ-012 ci_clk_en  out  1  start pulse to the multi-cycle fp unit.
REQ-013 ci_dataa  out  32  operand A to the unit.
REQ-014 ci_datab  out  32  operand B to the unit.
REQ-015 ci_result  in  32  unit result; valid while ci_done is high.
REQ-016 ci_done  in  1  unit completion strobe.
REQ-017 op_count  out  16  count of completed response handshakes.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP; state is registered.
REQ-019 IDLE: cmd_ready=1; when cmd_valid&&cmd_ready, latch cmd_dataa/cmd_datab into ci_dataa/ci_datab and go to ISSUE.
REQ-020 ISSUE: ci_clk_en=1 for exactly one cycle, then unconditionally go to WAIT.
REQ-021 ci_clk_en SHALL be 0 in every state other than ISSUE.
REQ-022 ci_dataa/ci_datab SHALL hold stable from ISSUE until leaving WAIT.
REQ-023 ci_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-024 WAIT: on ci_done=1, capture ci_result into rsp_result, clear rsp_timeout, and go to RESP.
REQ-025 RESP: rsp_valid=1; rsp_result and rsp_timeout hold stable; on rsp_ready=1 go to IDLE.
REQ-026 Latency: command accepted at edge N; ci_clk_en is high during cycle N+1; if ci_done is first high in WAIT cycle N+1+k (k>=1), rsp_valid rises at edge N+2+k.
REQ-027 No new command is accepted until the RESP handshake completes; throughput is at most one operation per 4 cycles.
REQ-028 op_count increments on each rsp_valid&&rsp_ready and saturates at 0xFFFF.

Reset
REQ-029 Reset asserted: state=IDLE; ci_clk_en, rsp_valid, rsp_timeout=0; ci_dataa, ci_datab, rsp_result=0; op_count=0.
REQ-030 Reset mid-operation aborts the operation with no response; ci_clk_en drops asynchronously; a ci_done arriving after release is ignored.

Configuration
REQ-031 Macro FP_CI_MASTER_TIMEOUT_EN defined: an 8-bit WAIT counter clears on entry to WAIT and increments each WAIT cycle.
REQ-032 With the macro, if the count reaches TIMEOUT_CYCLES without ci_done: rsp_result=0, rsp_timeout=1, go to RESP.
REQ-033 With the macro, ci_done and timeout in the same cycle: done wins.
REQ-034 Macro undefined: WAIT lasts until ci_done with no limit, no counter is synthesized, and rsp_timeout is tied to 0.

Verification
REQ-035 Unit model with done 3 cycles after clk_en, A=0x3F800000, B=0x40000000, unit returns 0x00000004 -> one ci_clk_en pulse; rsp_result=0x00000004 at edge N+5; op_count=1.
REQ-036 cmd_valid held high for 3 back-to-back ops, rsp_ready=1 -> cmd_ready low outside IDLE; exactly 3 clk_en pulses; op_count=3.
REQ-037 rsp_ready held low 10 cycles in RESP -> rsp_valid/rsp_result stable and cmd_ready=0 throughout.
REQ-038 Macro defined, TIMEOUT_CYCLES=4, unit never asserts done -> rsp_valid with rsp_timeout=1 and rsp_result=0 after 4 WAIT cycles; without the macro, rsp_valid stays 0.
REQ-039 reset_n pulsed low 2 cycles into WAIT, then done arrives -> all outputs 0 immediately, no response generated, op_count=0.
